// File: rtl/sd_cmd_tx.sv
// -----------------------------------------------------------------------------
// sd_cmd_tx
//
// This module is the host-side transmitter for the SD CMD line. It sends one
// 48-bit command frame, most significant bit first:
//
//   start(0) | transmission(1) | index[5:0] | argument[31:0] | CRC7 | end(1)
//
// The CRC7 is computed serially from the first 40 bits while they are shifted
// out, and then the seven CRC bits are sent. After the end bit the block keeps
// the CMD line released and stays busy for GAP_CYCLES cycles. This enforces
// the minimum command-to-command spacing (Ncc).
//
// Parameters
//   GAP_CYCLES  Number of cycles in the released, busy gap after the end bit.
//               Legal range is 1..255.
//
// Ports
//   sdClk     in   SD clock. All state advances on the rising edge.
//   rstN      in   Asynchronous active-low reset.
//   cmdStart  in   Request to send. It is sampled only while idle.
//   cmdIndex  in   Command index [5:0]. Captured when a start is accepted.
//   cmdArg    in   Command argument [31:0]. Captured when a start is accepted.
//   cmdOut    out  Serial CMD data to the pad. It is 1 whenever not driving.
//   cmdOe     out  CMD pad output enable. 1 means the host drives the line.
//   busy      out  A frame or gap is in progress. Starts are ignored.
//   done      out  One-cycle pulse in the first gap cycle.
//   crcVal    out  CRC7 of the most recent frame. It is valid from the CRC
//                  phase until the next accepted start.
//   dbgState  out  Current FSM state. Debug observation only.
//
// Handshake: cmdStart is a level request. It is accepted on the first rising
// edge where it is high while the block is idle. There is no queueing, so a
// request seen while busy is dropped. Holding cmdStart high therefore gives
// back-to-back frames separated by the gap plus one idle cycle.
// -----------------------------------------------------------------------------
module sd_cmd_tx #(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        sdClk,
  input  logic        rstN,
  input  logic        cmdStart,
  input  logic [5:0]  cmdIndex,
  input  logic [31:0] cmdArg,
  output logic        cmdOut,
  output logic        cmdOe,
  output logic        busy,
  output logic        done,
  output logic [6:0]  crcVal,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_CRC  = 3'd2,
    ST_END  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift-out.
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_e      state_q,   state_d;
  logic [39:0] shift_q,   shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  crc_q,     crc_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  logic        crc_fb;
  logic [6:0]  crc_sel;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sdClk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      crc_q     <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      crc_q     <= crc_d;
      gap_cnt_q <= gap_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    crc_d     = crc_q;
    gap_cnt_d = gap_cnt_q;
    // The feedback is taken from the bit currently on the line (shift MSB).
    crc_fb    = shift_q[39] ^ crc_q[6];

    case (state_q)
      ST_IDLE: begin
        if (cmdStart) begin
          shift_d   = {1'b0, 1'b1, cmdIndex, cmdArg};
          crc_d     = '0;
          bit_cnt_d = 6'd39;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        shift_d = {shift_q[38:0], 1'b0};
        crc_d   = {crc_q[5:0], 1'b0} ^ (crc_fb ? CRC7_POLY : 7'h00);
        if (bit_cnt_q == 6'd0) begin
          // This edge also retires bit 0, so all 40 bits are folded into the CRC.
          bit_cnt_d = 6'd6;
          state_d   = ST_CRC;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      ST_CRC: begin
        // The CRC is held while its bits are indexed out by the counter.
        if (bit_cnt_q == 6'd0) begin
          state_d = ST_END;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      ST_END: begin
        gap_cnt_d = GAP_LOAD;
        state_d   = ST_GAP;
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy and done are registered. Their values for the coming cycle are
    // derived from the state that cycle will be in.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_END);
  end

  // ---------------------------------------------------------------------------
  // Pad outputs. These are decoded from registers only, so cmdStart never
  // reaches a pin combinationally.
  // ---------------------------------------------------------------------------
  assign crc_sel = crc_q >> bit_cnt_q[2:0];

  always_comb begin
    cmdOut = 1'b1;
    cmdOe  = 1'b0;
    case (state_q)
      ST_SEND: begin
        cmdOe  = 1'b1;
        cmdOut = shift_q[39];
      end
      ST_CRC: begin
        cmdOe  = 1'b1;
        cmdOut = crc_sel[0];
      end
      ST_END: begin
        cmdOe  = 1'b1;
        cmdOut = 1'b1;
      end
      default: begin
        cmdOe  = 1'b0;
        cmdOut = 1'b1;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crcVal   = crc_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_tx
//
// This bench drives two instances side by side:
//   dut0  uses the default gap of 8 cycles.
//   dut1  uses GAP_CYCLES = 1.
//
// The frames they send are compared against an arithmetic reference. That
// reference builds the 48-bit frame with concatenation and computes the CRC7
// as the remainder of M(x)*x^7 divided by G(x) = x^7 + x^3 + 1, using long
// division.
// -----------------------------------------------------------------------------
module tb_sd_cmd_tx;

  localparam int GAP0 = 8;
  localparam int GAP1 = 1;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic sdClk;
  logic rstN;

  initial begin
    sdClk = 1'b0;
    forever #5 sdClk = ~sdClk;
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic        start0, start1;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;

  logic        out0, oe0, busy0, done0;
  logic        out1, oe1, busy1, done1;
  logic [6:0]  crc0, crc1;
  logic [2:0]  dbg0, dbg1;

  sd_cmd_tx #(.GAP_CYCLES(GAP0)) u_dut0 (
    .sdClk    (sdClk),
    .rstN     (rstN),
    .cmdStart (start0),
    .cmdIndex (cmd_idx),
    .cmdArg   (cmd_arg),
    .cmdOut   (out0),
    .cmdOe    (oe0),
    .busy     (busy0),
    .done     (done0),
    .crcVal   (crc0),
    .dbgState (dbg0)
  );

  sd_cmd_tx #(.GAP_CYCLES(GAP1)) u_dut1 (
    .sdClk    (sdClk),
    .rstN     (rstN),
    .cmdStart (start1),
    .cmdIndex (cmd_idx),
    .cmdArg   (cmd_arg),
    .cmdOut   (out1),
    .cmdOe    (oe1),
    .busy     (busy1),
    .done     (done1),
    .crcVal   (crc1),
    .dbgState (dbg1)
  );

  // These signals follow whichever DUT is selected for the current step.
  logic       sel;
  logic       mon_out, mon_oe, mon_busy, mon_done;
  logic [6:0] mon_crc;

  assign mon_out  = sel ? out1  : out0;
  assign mon_oe   = sel ? oe1   : oe0;
  assign mon_busy = sel ? busy1 : busy0;
  assign mon_done = sel ? done1 : done0;
  assign mon_crc  = sel ? crc1  : crc0;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, ref_crc7(msg), 1'b1};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver and monitor
  // ---------------------------------------------------------------------------
  logic [47:0] cap_bits;
  int          cap_idle, cap_oe, cap_gap, cap_done, cap_anom;
  bit          cap_done_first, cap_timeout;

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // The caller raises start at a negedge and then calls this task. If hold is
  // set, start is left high. If inj_at is not negative, a start request with
  // new index/argument values is applied at that bit position of the frame.
  task automatic capture(input bit hold, input int inj_at,
                         input logic [5:0] inj_idx, input logic [31:0] inj_arg);
    cap_bits = '0; cap_idle = 0; cap_oe = 0; cap_gap = 0;
    cap_done = 0; cap_anom = 0; cap_done_first = 0; cap_timeout = 0;
    @(negedge sdClk);
    while (mon_oe !== 1'b1 && cap_idle < 50) begin
      cap_idle++;
      @(negedge sdClk);
    end
    if (mon_oe !== 1'b1) cap_timeout = 1;
    while (mon_oe === 1'b1 && cap_oe < 60) begin
      cap_bits = {cap_bits[46:0], mon_out};
      if (mon_busy !== 1'b1) cap_anom++;
      if (mon_done === 1'b1) cap_done++;
      if (!hold) set_start(1'b0);
      if (cap_oe == inj_at) begin
        cmd_idx = inj_idx;
        cmd_arg = inj_arg;
        set_start(1'b1);
      end
      cap_oe++;
      @(negedge sdClk);
    end
    while (mon_busy === 1'b1 && cap_gap < 300) begin
      if (mon_oe !== 1'b0) cap_anom++;
      if (mon_done === 1'b1) begin
        cap_done++;
        if (cap_gap == 0) cap_done_first = 1;
      end
      cap_gap++;
      @(negedge sdClk);
    end
    if (mon_busy === 1'b1) cap_timeout = 1;
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp_bits,
                             input logic [6:0] exp_crc);
    check({tag, " timeout"},   64'(cap_timeout), 64'd0);
    check({tag, " idle"},      64'(cap_idle), 64'd0);
    check({tag, " bits"},      64'(cap_bits), 64'(exp_bits));
    check({tag, " oe_len"},    64'(cap_oe), 64'd48);
    check({tag, " gap_len"},   64'(cap_gap), 64'(sel ? GAP1 : GAP0));
    check({tag, " done_cnt"},  64'(cap_done), 64'd1);
    check({tag, " done_pos"},  64'(cap_done_first), 64'd1);
    check({tag, " anomalies"}, 64'(cap_anom), 64'd0);
    check({tag, " crcVal"},    64'(mon_crc), 64'(exp_crc));
  endtask

  // A global time limit so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [47:0] exp_bits;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    int          cnt;

    sel = 1'b0; start0 = 1'b0; start1 = 1'b0;
    cmd_idx = '0; cmd_arg = '0;
    rstN = 1'b0;
    repeat (3) @(negedge sdClk);

    // Reset values. IDLE is the first enum member, so its code is 0.
    check("rst cmdOut", 64'(out0), 64'd1);
    check("rst cmdOe",  64'(oe0), 64'd0);
    check("rst busy",   64'(busy0), 64'd0);
    check("rst done",   64'(done0), 64'd0);
    check("rst crcVal", 64'(crc0), 64'd0);
    check("rst state",  64'(dbg0), 64'd0);
    check("rst busy1",  64'(busy1), 64'd0);
    check("rst state1", 64'(dbg1), 64'd0);
    rstN = 1'b1;
    @(negedge sdClk);

    // CMD0, argument 0
    cmd_idx = 6'd0; cmd_arg = 32'h0; start0 = 1'b1;
    capture(1'b0, -1, 6'd0, 32'h0);
    check_frame("cmd0", 48'h400000000095, 7'h4A);

    // CMD8, argument 0x1AA
    cmd_idx = 6'd8; cmd_arg = 32'h000001AA; start0 = 1'b1;
    capture(1'b0, -1, 6'd0, 32'h0);
    check_frame("cmd8", 48'h48000001AA87, 7'h43);

    // Back-to-back CMD55 then CMD17 with start held high. The index is
    // changed during the first frame and must only affect the second one.
    cmd_idx = 6'd55; cmd_arg = 32'h0; start0 = 1'b1;
    capture(1'b1, 5, 6'd17, 32'h0);
    check_frame("cmd55", 48'h770000000065, 7'h32);
    capture(1'b0, -1, 6'd0, 32'h0);
    check_frame("cmd17", 48'h510000000055, 7'h2A);

    // A start pulse mid-frame with different contents must be ignored.
    r_idx = 6'($urandom_range(0, 63));
    r_arg = $urandom;
    cmd_idx = r_idx; cmd_arg = r_arg; start0 = 1'b1;
    exp_q.push_back(ref_frame(r_idx, r_arg));
    capture(1'b0, 10, ~r_idx, ~r_arg);
    exp_bits = exp_q.pop_front();
    check_frame("midpulse", exp_bits, exp_bits[7:1]);
    cnt = 0;
    repeat (5) begin
      if (oe0 !== 1'b0 || busy0 !== 1'b0) cnt++;
      @(negedge sdClk);
    end
    check("midpulse no_requeue", 64'(cnt), 64'd0);

    // Reset asserted during bit 20. The outputs must change with no clock edge.
    cmd_idx = 6'd9; cmd_arg = $urandom; start0 = 1'b1;
    cnt = 0;
    @(negedge sdClk);
    while (oe0 !== 1'b1 && cnt < 10) begin
      cnt++;
      @(negedge sdClk);
    end
    check("rstmid frame_started", 64'(oe0), 64'd1);
    start0 = 1'b0;
    repeat (20) @(negedge sdClk);
    #2 rstN = 1'b0;
    #1;
    check("rstmid cmdOe",  64'(oe0), 64'd0);
    check("rstmid cmdOut", 64'(out0), 64'd1);
    check("rstmid busy",   64'(busy0), 64'd0);
    check("rstmid crcVal", 64'(crc0), 64'd0);
    @(negedge sdClk);
    rstN = 1'b1;
    r_idx = 6'($urandom_range(0, 63));
    r_arg = $urandom;
    cmd_idx = r_idx; cmd_arg = r_arg; start0 = 1'b1;
    exp_q.push_back(ref_frame(r_idx, r_arg));
    capture(1'b0, -1, 6'd0, 32'h0);
    exp_bits = exp_q.pop_front();
    check_frame("after_rst", exp_bits, exp_bits[7:1]);

    // Random frames on both builds (the gap is 8 on dut0 and 1 on dut1).
    for (int n = 0; n < 8; n++) begin
      sel = (n % 2 == 1);
      r_idx = 6'($urandom_range(0, 63));
      r_arg = $urandom;
      cmd_idx = r_idx; cmd_arg = r_arg;
      set_start(1'b1);
      exp_q.push_back(ref_frame(r_idx, r_arg));
      capture(1'b0, -1, 6'd0, 32'h0);
      exp_bits = exp_q.pop_front();
      check_frame($sformatf("rand%0d", n), exp_bits, exp_bits[7:1]);
      check($sformatf("rand%0d busy_total", n), 64'(cap_oe + cap_gap),
            64'(48 + (sel ? GAP1 : GAP0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
